// File: rtl/neo_pkg.sv
// Shared types, default sizing and the output clamp for the NEO engine.
package neo_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Default sizing: N-bit samples, M-deep memories, exact-width result.
  localparam int N_DEF  = 8;
  localparam int M_DEF  = 16;
  localparam int W_DEF  = 2 * N_DEF + 1;
  localparam int AW_DEF = $clog2(M_DEF);
  localparam int LW_DEF = $clog2(M_DEF + 1);

  // Clamp a sign-extended difference into a w-bit signed range (w <= 63).
  // ovf reports that clamping changed the value.
  function automatic logic signed [63:0] sat_to_w(input logic signed [63:0] d,
                                                  input int w,
                                                  output logic ovf);
    logic signed [63:0] hi, lo;
    hi  = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo  = -(64'sd1 <<< (w - 1));
    ovf = 1'b0;
    if (d > hi) begin
      ovf = 1'b1;
      return hi;
    end
    if (d < lo) begin
      ovf = 1'b1;
      return lo;
    end
    return d;
  endfunction

endpackage

// File: rtl/neo_engine_core.sv
// 3-tap window and psi = x[k]^2 - x[k-1]*x[k+1] datapath with output clamp.
// A psi is produced on each incoming sample once the window holds x[k].
module neo_core
  import neo_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int W = W_DEF
) (
  input  logic                Clk,
  input  logic                reset,
  input  logic                clr,
  input  logic signed [N-1:0] s_in,
  input  logic                s_vld,
  output logic                fire,
  output logic [W-1:0]        psi,
  output logic                o_vld,
  output logic                o_sat
);

  logic signed [N-1:0]   prev, cur;
  logic                  cur_vld;
  logic signed [2*N-1:0] p_sq, p_x;
  logic signed [2*N:0]   dif;
  logic signed [63:0]    ext;
  logic [W-1:0]          psi_n;
  logic                  ovf_n;

  assign fire = s_vld & cur_vld;

  // Full-width products and a difference one bit wider so it cannot overflow.
  always_comb begin
    p_sq  = (2*N)'(cur) * (2*N)'(cur);
    p_x   = (2*N)'(prev) * (2*N)'(s_in);
    dif   = (2*N+1)'(p_sq) - (2*N+1)'(p_x);
    ext   = 64'(dif);
    ovf_n = 1'b0;
    psi_n = W'(sat_to_w(ext, W, ovf_n));
  end

  // Window shift on each sample; psi register updates only when a psi fires.
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      prev    <= '0;
      cur     <= '0;
      cur_vld <= 1'b0;
      psi     <= '0;
      o_vld   <= 1'b0;
      o_sat   <= 1'b0;
    end else begin
      o_vld <= fire;
      if (clr) begin
        prev    <= '0;
        cur     <= '0;
        cur_vld <= 1'b0;
      end else if (s_vld) begin
        prev    <= cur;
        cur     <= s_in;
        cur_vld <= 1'b1;
      end
      if (fire) begin
        psi   <= psi_n;
        o_sat <= ovf_n;
      end
    end
  end

endmodule

// File: rtl/neo_engine.sv
// Frame sequencer for the NEO datapath: reads len samples, appends the zero
// pad, writes psi back, and tracks saturation and threshold spikes.
module neo_engine
  import neo_pkg::*;
#(
  parameter  int N  = N_DEF,
  parameter  int M  = M_DEF,
  parameter  int W  = 2 * N + 1,
  localparam int AW = $clog2(M),
  localparam int LW = $clog2(M + 1)
) (
  input  logic          Clk,
  input  logic          reset,
  input  logic          start,
  input  logic [LW-1:0] len,
  input  logic [W-1:0]  thresh,
  input  logic [N-1:0]  rdata,
  output logic [AW-1:0] raddr,
  output logic [AW-1:0] waddr,
  output logic [W-1:0]  wdata,
  output logic          we,
  output logic          busy,
  output logic          done,
  output logic          sat_flag,
  output logic [LW-1:0] spike_cnt
);

  state_t               state, nstate;
  logic [LW-1:0]        len_q, len_c, spk_q;
  logic signed [W-1:0]  thr_q;
  logic [1:0]           dcnt;
  logic [AW-1:0]        wcnt;
  logic                 rd_vld, pad_vld, sat_q, go, rd_last, gt;
  logic                 fire, o_sat;
  logic signed [N-1:0]  s_in;

  assign go      = (state == IDLE) && start;
  assign len_c   = (len > LW'(M)) ? LW'(M) : len;
  assign rd_last = (LW'(raddr) == len_q - LW'(1));
  assign s_in    = pad_vld ? '0 : $signed(rdata);
  assign busy    = (state == READ) || (state == DRAIN);
  assign done    = (state == DONE);
  assign gt      = we && ($signed(wdata) > thr_q);
  assign spike_cnt = spk_q + LW'(gt);
  assign sat_flag  = sat_q | (we & o_sat);

  // State register.
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= nstate;
  end

  // Next state: DRAIN covers the pad sample plus two pipeline stages.
  always_comb begin
    nstate = state;
    case (state)
      IDLE:  if (start) nstate = (len_c == '0) ? DRAIN : READ;
      READ:  if (rd_last) nstate = DRAIN;
      DRAIN: if (len_q == '0 || dcnt == 2'd2) nstate = DONE;
      DONE:  nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  // Frame registers: length/threshold capture, read address, pad insertion.
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      len_q   <= '0;
      thr_q   <= '0;
      raddr   <= '0;
      dcnt    <= '0;
      rd_vld  <= 1'b0;
      pad_vld <= 1'b0;
    end else begin
      if (go) begin
        len_q <= len_c;
        thr_q <= $signed(thresh);
      end
      if (state == READ && !rd_last) raddr <= raddr + AW'(1);
      else if (state == DONE)        raddr <= '0;
      dcnt    <= (state == DRAIN) ? dcnt + 2'd1 : 2'd0;
      rd_vld  <= (state == READ);
      pad_vld <= rd_vld && (state != READ);
    end
  end

  // Write address follows the psi register; counters clear on an honoured start.
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      wcnt  <= '0;
      waddr <= '0;
      spk_q <= '0;
      sat_q <= 1'b0;
    end else begin
      if (go) wcnt <= '0;
      else if (fire) begin
        waddr <= wcnt;
        wcnt  <= wcnt + AW'(1);
      end
      if (go)      spk_q <= '0;
      else if (gt) spk_q <= spk_q + LW'(1);
      if (go)                sat_q <= 1'b0;
      else if (we && o_sat)  sat_q <= 1'b1;
    end
  end

  neo_core #(.N(N), .W(W)) u_core (
    .Clk   (Clk),
    .reset (reset),
    .clr   (go),
    .s_in  (s_in),
    .s_vld (rd_vld | pad_vld),
    .fire  (fire),
    .psi   (wdata),
    .o_vld (we),
    .o_sat (o_sat)
  );

endmodule

// File: doc/neo_engine.md
Name: neo_engine

Overview:
- Parametrised Nonlinear Energy Operator engine: psi[n] = x[n]^2 - x[n-1]*x[n+1] over a frame of len samples.
- Frame is read from the sample memory and psi is written back to the result memory.
- Adds start/busy/done control, zero-padded frame edges, a write strobe, output saturation and a per-frame threshold spike count.
- Sits between the sample memory (read port) and the result memory (write port) in the NEO datapath.

Parameters:
- N, 8, input sample width, signed two's complement.
- M, 16, memory depth in locations; maximum frame length.
- W, 2*N+1, output width, signed; W >= 2N+1 is exact, W < 2N+1 saturates.

Ports:
- Clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle frame request; honoured only in IDLE.
- len  input  $clog2(M+1)  frame length, sampled when start is honoured.
- thresh  input  W  signed spike threshold, sampled when start is honoured.
- rdata  input  N  sample memory read data; one-cycle read latency.
- raddr  output  $clog2(M)  sample memory read address.
- waddr  output  $clog2(M)  result memory write address.
- wdata  output  W  psi value to write.
- we  output  1  result memory write strobe.
- busy  output  1  frame in progress.
- done  output  1  one-cycle pulse at frame end.
- sat_flag  output  1  sticky per frame: any psi saturated.
- spike_cnt  output  $clog2(M+1)  count of psi > thresh in the current frame.

Behaviour:
- Clock and reset: Clk; reset asynchronous, active-low. Reset drives all outputs, pipeline registers and state to 0/IDLE; no write is issued during or after reset. Reset mid-frame abandons the frame, with no done pulse.
- FSM states:
  - IDLE: start=1 leaves IDLE.
  - READ: issue len reads.
  - DRAIN: flush the final padded sample.
  - DONE: one cycle, done=1, then back to IDLE.
- Start handling:
  - Let S be the cycle in which start is sampled high in IDLE.
  - len is clamped to M.
  - spike_cnt and sat_flag are cleared in cycle S+1.
  - start outside IDLE is ignored.
- Read timing: raddr=k in cycle S+1+k for k = 0..len-1; x[k] is on rdata in cycle S+2+k. raddr holds its last value after reads finish and returns to 0 in IDLE.
- Edge padding: x[-1] = x[len] = 0. The padded x[len] is inserted internally in cycle S+2+len, not read from memory.
- Compute and write:
  - psi[k] is computed when x[k+1] is available and registered.
  - Write strobe: we=1, waddr=k, wdata=psi[k] in cycle S+4+k, for k = 0..len-1.
  - Last write is in cycle S+3+len; done=1 in cycle S+4+len.
- busy=1 from S+1 through S+3+len inclusive.
- len=0: no reads, no writes, done=1 in cycle S+2.
- len=1: single write psi[0] = x[0]^2.
- Arithmetic:
  - Products are computed at full 2N width, signed.
  - The difference is computed at 2N+1 bits and never overflows.
  - If W < 2N+1, the result is clamped to [-2^(W-1), 2^(W-1)-1] and sat_flag is set (sticky until the next start).
  - If W >= 2N+1, the result is sign-extended.
- spike_cnt increments in the same cycle as a write whose wdata > thresh (signed compare on the saturated value). Max value len; no wrap. spike_cnt and sat_flag hold after done until the next honoured start.
- Back-to-back: start asserted in the cycle after done is honoured normally.
- we=0 in all cycles other than those listed above; wdata and waddr hold their last values when we=0.

Decomposition:
- neo_pkg holds:
  - the state enum (IDLE, READ, DRAIN, DONE);
  - the address/count width localparams derived from N, M, W;
  - a sat_to_w function (2N+1 -> W clamp with overflow indicator).
- Sub-module neo_core: 3-tap window registers, the two multipliers, the subtractor and the saturator. Interface is sample-in + valid / psi-out + valid + sat.
- neo_engine holds the FSM, address counters, padding, spike counter and flags.

Test Plan:
- N=8, W=17, len=3, x=[3,5,2] -> writes (addr 0,9), (1,19), (2,4) in cycles S+4..S+6; done at S+7; busy S+1..S+6.
- N=8, W=8, len=3, x=[-128,127,-128] -> wdata 127, -128, 127; sat_flag=1; thresh=0 gives spike_cnt=2.
- len=0 -> we never high, done at S+2; len=1, x=[-4] -> single write 16 at addr 0, done at S+5.
- len=20 with M=16 -> clamped to 16; raddr 0..15; 16 writes; addresses never wrap.
- Start pulses while busy and a back-to-back start the cycle after done -> the first is ignored, the second runs; spike_cnt and sat_flag are cleared at frame 2.
- Reset asserted at cycle S+5 of a len=8 frame -> we, busy, done immediately 0; no further writes; next start runs a clean frame with correct results.
